// File: rtl/floating_if.sv
// floating_if: operand/result bundle for the sequential binary32 multiplier (o_done only with FLOATING_DONE_EN)
interface floating_if;
  logic i_load;
  logic [31:0] i_a, i_b, o_res;
`ifdef FLOATING_DONE_EN
  logic o_done;
  modport master(output i_load, i_a, i_b, input o_res, o_done);
  modport slave(input i_load, i_a, i_b, output o_res, o_done);
`else
  modport master(output i_load, i_a, i_b, input o_res);
  modport slave(input i_load, i_a, i_b, output o_res);
`endif
endinterface

// File: rtl/floating.sv
// floating: iterative shift-add IEEE-754 binary32 multiplier, truncating; FLOATING_DONE_EN adds a one-cycle o_done pulse
module floating #(
  parameter int WIDTH = 32,
  parameter int MANT = 24
) (
  input logic i_clk,
  input logic i_rst_n,
  floating_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, MUL, NORM, PACK} state_t;
  localparam logic [1:0] SP_NONE = 2'd0, SP_ZERO = 2'd1, SP_INF = 2'd2, SP_NAN = 2'd3;
  state_t state, nxt;
  logic s;
  logic [1:0] sp;
  logic [8:0] esum;
  logic [MANT-1:0] ma, nm;
  logic [2*MANT-1:0] p;
  logic [4:0] cnt;
  logic signed [9:0] ne;
  logic [WIDTH-1:0] res;
  logic [7:0] ea_r, eb_r, ea, eb;
  logic [22:0] fa, fb;
  logic a_z, b_z, a_i, b_i, a_n, b_n;
  logic [1:0] sp_n;
  logic [24:0] acc;
  logic [5:0] lz;
  logic signed [9:0] ne_n, sh;
  logic [MANT-1:0] nm_n;
  logic [22:0] sub;
  logic [WIDTH-1:0] pk;
  assign ea_r = bus.i_a[30:23];
  assign eb_r = bus.i_b[30:23];
  assign fa = bus.i_a[22:0];
  assign fb = bus.i_b[22:0];
  assign a_z = ea_r == 8'h00 && fa == 23'd0;
  assign b_z = eb_r == 8'h00 && fb == 23'd0;
  assign a_i = ea_r == 8'hFF && fa == 23'd0;
  assign b_i = eb_r == 8'hFF && fb == 23'd0;
  assign a_n = ea_r == 8'hFF && fa != 23'd0;
  assign b_n = eb_r == 8'hFF && fb != 23'd0;
  // subnormals behave as exponent 1 with a cleared hidden bit
  assign ea = ea_r == 8'h00 ? 8'd1 : ea_r;
  assign eb = eb_r == 8'h00 ? 8'd1 : eb_r;
  assign sp_n = (a_n || b_n || (a_i && b_z) || (b_i && a_z)) ? SP_NAN :
                (a_i || b_i) ? SP_INF : (a_z || b_z) ? SP_ZERO : SP_NONE;
  assign acc = {1'b0, p[47:24]} + (p[0] ? {1'b0, ma} : 25'd0);
  always_comb begin
    lz = '0;
    for (int i = 0; i < 2 * MANT; i++) if (p[i]) lz = 6'(47 - i);
  end
  assign nm_n = 24'((p << lz) >> 24);
  assign ne_n = $signed({1'b0, esum}) - 10'sd126 - $signed({4'b0, lz});
  assign sh = 10'sd1 - ne;
  assign sub = 23'(nm >> sh[4:0]);
  assign pk = sp == SP_NAN ? 32'hFFFF_FFFF :
              (sp == SP_INF || ne >= 10'sd255) ? {s, 8'hFF, 23'd0} :
              (sp == SP_ZERO || sh > 10'sd24) ? {s, 31'd0} :
              ne <= 10'sd0 ? {s, 8'h00, sub} : {s, ne[7:0], nm[22:0]};
  always_comb begin
    nxt = bus.i_load ? LOAD :
          state == LOAD ? MUL :
          state == MUL ? (cnt == 5'(MANT - 1) ? NORM : MUL) :
          state == NORM ? PACK : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s <= 1'b0;
      sp <= SP_NONE;
      esum <= '0;
      ma <= '0;
      p <= '0;
      cnt <= '0;
      nm <= '0;
      ne <= '0;
      res <= '0;
    end else if (bus.i_load) begin
      s <= bus.i_a[31] ^ bus.i_b[31];
      sp <= sp_n;
      esum <= {1'b0, ea} + {1'b0, eb};
      ma <= {ea_r != 8'h00, fa};
      p <= {24'd0, eb_r != 8'h00, fb};
      cnt <= '0;
    end else if (state == MUL) begin
      p <= {acc, p[23:1]};
      cnt <= cnt + 5'd1;
    end else if (state == NORM) begin
      nm <= nm_n;
      ne <= ne_n;
    end else if (state == PACK) res <= pk;
  end
  assign bus.o_res = res;
`ifdef FLOATING_DONE_EN
  logic done;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) done <= 1'b0;
    else done <= !bus.i_load && state == PACK;
  assign bus.o_done = done;
`endif
endmodule

// File: tb/tb_floating.sv
// tb_floating: table-driven directed checks of the binary32 multiplier plus reset/reload sequences
module tb_floating;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  floating_if f();
  floating dut(.i_clk(clk), .i_rst_n(rst_n), .bus(f));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;
  vec_t v[10];
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic load_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    f.i_a = a;
    f.i_b = b;
    f.i_load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    f.i_load = 1'b0;
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset res", f.o_res, 32'h0);
    rst_n = 1'b1;
  endtask
  task automatic wait_result(input string nm, input logic [31:0] exp);
    int pulses;
    pulses = 0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
`ifdef FLOATING_DONE_EN
      if (f.o_done) begin
        pulses++;
        check({nm, " res at done"}, f.o_res, exp);
      end
`endif
      if (c == 30) check({nm, " at 30"}, f.o_res, exp);
    end
    check({nm, " at 36"}, f.o_res, exp);
`ifdef FLOATING_DONE_EN
    check({nm, " done pulses"}, 32'(pulses), 32'd1);
`endif
  endtask
  initial begin
    v[0] = '{32'h40600000, 32'h425D0000, 32'h43416000};
    v[1] = '{32'hC0000000, 32'h3E000000, 32'hBE800000};
    v[2] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    v[3] = '{32'h7F800000, 32'h80000000, 32'hFFFFFFFF};
    v[4] = '{32'h7F800000, 32'h807FFFFF, 32'hFF800000};
    v[5] = '{32'hFF800000, 32'hFF800000, 32'h7F800000};
    v[6] = '{32'h4091EB85, 32'h7F400000, 32'h7F800000};
    v[7] = '{32'h80000000, 32'h80000000, 32'h00000000};
    v[8] = '{32'h00800000, 32'h3F000000, 32'h00400000};
    v[9] = '{32'h14A9999A, 32'h1FC00000, 32'h00000000};
    f.i_load = 1'b0;
    f.i_a = '0;
    f.i_b = '0;
    repeat (2) @(negedge clk);
    check("initial reset res", f.o_res, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pulse_reset();
      load_op(v[i].a, v[i].b);
      wait_result($sformatf("vec%0d", i), v[i].r);
    end
    pulse_reset();
    load_op(32'h40600000, 32'h425D0000);
    wait_result("pre-abort", 32'h43416000);
    load_op(32'hC0000000, 32'h3E000000);
    repeat (11) @(negedge clk);
    check("hold during mul", f.o_res, 32'h43416000);
    rst_n = 1'b0;
    #1;
    check("async reset mid-mul", f.o_res, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (36) @(negedge clk);
    check("aborted op stays 0", f.o_res, 32'h0);
    load_op(32'h40600000, 32'h425D0000);
    wait_result("before reload", 32'h43416000);
    load_op(32'h00800000, 32'h3F000000);
    repeat (10) @(negedge clk);
    check("hold before reload", f.o_res, 32'h43416000);
    load_op(32'hC0000000, 32'h3E000000);
    check("hold after reload", f.o_res, 32'h43416000);
    wait_result("reload", 32'hBE800000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
